// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one sync-read single-port memory between two requesters
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_din,
  input  logic [DATA_WIDTH-1:0]   mem_dout,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    RD   = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                st;
  logic                  last_grant;   // requester that won the most recent accept
  logic                  rd_owner;     // requester whose read is in flight
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            resp_valid_q;

  logic any_valid;
  logic grant;
  logic accept;

  // On a tie the requester that did not win last time gets the memory
  assign any_valid = |req_valid;
  assign grant     = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
  // Gated by rst_n so nothing is accepted or driven to memory while reset is held
  assign accept    = rst_n && (st == ARB) && any_valid;

  // Combinational grant path: route the winning requester straight to the memory port
  always_comb begin
    req_ready = 2'b00;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    if (accept) begin
      req_ready[grant] = 1'b1;
      mem_en           = 1'b1;
      mem_we           = req_we[grant];
      mem_addr         = grant ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                               : req_addr[ADDR_WIDTH-1:0];
      mem_din          = grant ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                               : req_wdata[DATA_WIDTH-1:0];
    end
  end

  // Sequencer: writes complete in ARB, reads go ARB -> RD (capture) -> RESP (handshake)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= ARB;
      last_grant   <= 1'b1;
      rd_owner     <= 1'b0;
      rdata_q      <= '0;
      resp_valid_q <= 2'b00;
    end else begin
      case (st)
        ARB: begin
          if (any_valid) begin
            last_grant <= grant;
            if (!req_we[grant]) begin
              rd_owner <= grant;
              st       <= RD;
            end
          end
        end
        RD: begin
          rdata_q      <= mem_dout;
          resp_valid_q <= rd_owner ? 2'b10 : 2'b01;
          st           <= RESP;
        end
        RESP: begin
          if (resp_ready[rd_owner]) begin
            resp_valid_q <= 2'b00;
            st           <= ARB;
          end
        end
        default: begin
          resp_valid_q <= 2'b00;
          st           <= ARB;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign state      = st;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_ready, req_we, resp_valid, resp_ready;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] resp_rdata, mem_din, mem_dout;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0]    state;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .state(state)
  );

  always #5 clk = ~clk;

  // Behavioural single-port synchronous-read memory
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_din;
      else        mem_dout <= mem[mem_addr];
    end
  end

  // Requester stimulus
  logic       rv  [2];
  logic       rwe [2];
  logic [7:0] ra  [2];
  logic [7:0] rd  [2];
  assign req_valid = {rv[1], rv[0]};
  assign req_we    = {rwe[1], rwe[0]};
  assign req_addr  = {ra[1], ra[0]};
  assign req_wdata = {rd[1], rd[0]};

  // Reference model: shadow memory, round-robin pointer, one outstanding read
  logic [7:0] ref_mem [256];
  int         ref_last;
  bit         pend;
  int         pend_id;
  logic [7:0] pend_data;
  int         age;
  bit         acc [2];
  logic [7:0] last_resp;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model at the edge
  task automatic tick();
    int g;
    bit any;
    g = 0;
    acc[0] = 0;
    acc[1] = 0;
    any = rv[0] || rv[1];
    #1;
    if (!pend) begin
      if (any) begin
        g = (rv[0] && rv[1]) ? (1 - ref_last) : (rv[1] ? 1 : 0);
        chk("req_ready", {30'd0, req_ready}, 32'd1 << g);
        chk("mem_en", {31'd0, mem_en}, 32'd1);
        chk("mem_we", {31'd0, mem_we}, {31'd0, rwe[g]});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, ra[g]});
        chk("mem_din", {24'd0, mem_din}, {24'd0, rd[g]});
      end else begin
        chk("req_ready_idle", {30'd0, req_ready}, 32'd0);
        chk("mem_en_idle", {31'd0, mem_en}, 32'd0);
        chk("mem_addr_idle", {24'd0, mem_addr}, 32'd0);
      end
      chk("state_arb", {30'd0, state}, 32'd0);
      chk("resp_valid_arb", {30'd0, resp_valid}, 32'd0);
    end else begin
      chk("req_ready_busy", {30'd0, req_ready}, 32'd0);
      chk("mem_en_busy", {31'd0, mem_en}, 32'd0);
      if (age == 1) begin
        chk("state_rd", {30'd0, state}, 32'd1);
        chk("resp_valid_rd", {30'd0, resp_valid}, 32'd0);
      end else begin
        chk("state_resp", {30'd0, state}, 32'd2);
        chk("resp_valid", {30'd0, resp_valid}, 32'd1 << pend_id);
        chk("resp_rdata", {24'd0, resp_rdata}, {24'd0, pend_data});
        if (resp_ready[pend_id]) last_resp = resp_rdata;
      end
    end
    @(posedge clk);
    if (!pend && any) begin
      ref_last = g;
      acc[g] = 1;
      if (rwe[g]) begin
        ref_mem[ra[g]] = rd[g];
      end else begin
        pend = 1;
        pend_id = g;
        pend_data = ref_mem[ra[g]];
        age = 1;
      end
    end else if (pend) begin
      if (age >= 2 && resp_ready[pend_id]) pend = 0;
      else if (age < 2) age++;
    end
    #1;
  endtask

  task automatic do_req(input int i, input bit we, input logic [7:0] a, input logic [7:0] d);
    rv[i] = 1; rwe[i] = we; ra[i] = a; rd[i] = d;
    acc[i] = 0;
    for (int k = 0; k < 20 && !acc[i]; k++) tick();
    chk("accept_wait", {31'd0, acc[i]}, 32'd1);
    rv[i] = 0;
  endtask

  task automatic drain();
    resp_ready = 2'b11;
    for (int k = 0; k < 20 && pend; k++) tick();
    chk("drain_wait", {31'd0, pend}, 32'd0);
  endtask

  initial begin
    int n0, n1;
    for (int a = 0; a < 256; a++) begin
      mem[a] = 8'h00;
      ref_mem[a] = 8'h00;
    end
    mem_dout = 8'h00;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 0; rwe[i] = 0; ra[i] = 0; rd[i] = 0; acc[i] = 0;
    end
    resp_ready = 2'b00;
    ref_last = 1; pend = 0; pend_id = 0; pend_data = 0; age = 0; last_resp = 0;

    // Reset: nothing accepted while held, even with both requesting
    rst_n = 1'b0;
    rv[0] = 1; rv[1] = 1;
    #3;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_resp_valid", {30'd0, resp_valid}, 32'd0);
    rv[0] = 0; rv[1] = 0;
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // Contention: continuous writes from both, alternating from req0
    n0 = 0; n1 = 0;
    rv[0] = 1; rwe[0] = 1; ra[0] = 8'h01; rd[0] = 8'($urandom);
    rv[1] = 1; rwe[1] = 1; ra[1] = 8'h80; rd[1] = 8'($urandom);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("contention_order", {31'd0, acc[0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("contention_rate", {31'd0, acc[0] | acc[1]}, 32'd1);
      if (acc[0]) begin n0++; ra[0] = 8'(8'h01 + n0); rd[0] = 8'($urandom); end
      if (acc[1]) begin n1++; ra[1] = 8'(8'h80 + n1); rd[1] = 8'($urandom); end
    end
    rv[0] = 0; rv[1] = 0;
    tick();
    for (int a = 0; a < 4; a++) begin
      chk("contention_mem0", {24'd0, mem[8'(1 + a)]}, {24'd0, ref_mem[8'(1 + a)]});
      chk("contention_mem1", {24'd0, mem[8'(8'h80 + a)]}, {24'd0, ref_mem[8'(8'h80 + a)]});
    end

    // Single requester write then read
    resp_ready = 2'b01;
    do_req(0, 1, 8'h10, 8'hA5);
    do_req(0, 0, 8'h10, 8'h00);
    drain();
    chk("single_rdata", {24'd0, last_resp}, 32'h0A5);

    // Cross-requester coherence: read right after the other side's write
    do_req(1, 1, 8'h20, 8'h3C);
    do_req(0, 0, 8'h20, 8'h00);
    drain();
    chk("coherence_rdata", {24'd0, last_resp}, 32'h03C);

    // Backpressure on req1's response while req0 waits with a write
    resp_ready = 2'b00;
    do_req(1, 0, 8'hFF, 8'h00);
    rv[0] = 1; rwe[0] = 1; ra[0] = 8'h30; rd[0] = 8'h5A;
    for (int k = 0; k < 6; k++) tick();
    resp_ready = 2'b10;
    tick();
    chk("bp_handshake", {31'd0, pend}, 32'd0);
    resp_ready = 2'b00;
    tick();
    chk("bp_req0_next", {31'd0, acc[0]}, 32'd1);
    rv[0] = 0;

    // Address boundaries
    resp_ready = 2'b11;
    do_req(0, 1, 8'h00, 8'h11);
    do_req(1, 1, 8'hFF, 8'hEE);
    do_req(0, 0, 8'h00, 8'h00);
    drain();
    chk("boundary_lo", {24'd0, last_resp}, 32'h011);
    do_req(1, 0, 8'hFF, 8'h00);
    drain();
    chk("boundary_hi", {24'd0, last_resp}, 32'h0EE);

    // Reset in the middle of a response discards it
    resp_ready = 2'b00;
    do_req(0, 0, 8'h10, 8'h00);
    tick();
    chk("pre_rst_resp_valid", {30'd0, resp_valid}, 32'd1);
    rv[1] = 1; rwe[1] = 1; ra[1] = 8'h40; rd[1] = 8'h77;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_resp_valid", {30'd0, resp_valid}, 32'd0);
    chk("midrst_state", {30'd0, state}, 32'd0);
    chk("midrst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("midrst_mem_en", {31'd0, mem_en}, 32'd0);
    rv[1] = 0;
    pend = 0; ref_last = 1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    resp_ready = 2'b01;
    do_req(0, 0, 8'h10, 8'h00);
    drain();
    chk("post_rst_rdata", {24'd0, last_resp}, {24'd0, ref_mem[8'h10]});

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] || acc[i]) begin
          rv[i]  = ($urandom_range(0, 3) != 0);
          rwe[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 3) == 0) ra[i] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
          else ra[i] = 8'($urandom_range(0, 15));
          rd[i] = 8'($urandom);
        end
      end
      resp_ready = 2'($urandom);
      tick();
    end
    rv[0] = 0; rv[1] = 0;
    drain();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
